// File: rtl/adder_operand_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : adder_operand_sequencer
// Description : Feeds a wide operand pair byte-serially (LSB first) through an
//               external 8-bit combinational adder and collects the full sum.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_operand_sequencer #(
    parameter int NWORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [8*NWORDS-1:0]   a_in,
    input  logic [8*NWORDS-1:0]   b_in,
    input  logic                  cin_in,
    output logic                  busy,
    output logic                  done,
    output logic [8*NWORDS-1:0]   sum_out,
    output logic                  cout_out,
    output logic [7:0]            add_a,
    output logic [7:0]            add_b,
    output logic                  add_cin,
    input  logic [7:0]            add_s,
    input  logic                  add_cout
);

    localparam int W    = 8 * NWORDS;
    localparam int IDXW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    localparam logic [1:0]      c_IDLE     = 2'd0;
    localparam logic [1:0]      c_ADD      = 2'd1;
    localparam logic [1:0]      c_DONE     = 2'd2;
    localparam logic [IDXW-1:0] c_LAST_IDX = IDXW'(NWORDS - 1);

    logic [1:0]      r_state, w_state_nxt;
    logic [IDXW-1:0] r_idx,   w_idx_nxt;
    logic [W-1:0]    r_a,     w_a_nxt;
    logic [W-1:0]    r_b,     w_b_nxt;
    logic [W-1:0]    r_work,  w_work_nxt;
    logic [W-1:0]    r_sum,   w_sum_nxt;
    logic            r_cin,   w_cin_nxt;
    logic            r_carry, w_carry_nxt;
    logic            r_cout,  w_cout_nxt;

    logic [7:0]      w_byte_a;
    logic [7:0]      w_byte_b;
    logic [W-1:0]    w_work_upd;

    // Byte selection by index; everything here comes from registers so the
    // round trip through the external adder fits in one cycle.
    always_comb begin
        w_byte_a   = '0;
        w_byte_b   = '0;
        w_work_upd = r_work;
        for (int i = 0; i < NWORDS; i++) begin
            if (r_idx == IDXW'(i)) begin
                w_byte_a              = r_a[8*i +: 8];
                w_byte_b              = r_b[8*i +: 8];
                w_work_upd[8*i +: 8]  = add_s;
            end
        end
    end

    always_comb begin
        busy     = (r_state == c_ADD);
        done     = (r_state == c_DONE);
        sum_out  = r_sum;
        cout_out = r_cout;
        add_a    = busy ? w_byte_a : 8'd0;
        add_b    = busy ? w_byte_b : 8'd0;
        add_cin  = busy ? ((r_idx == '0) ? r_cin : r_carry) : 1'b0;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_cin_nxt   = r_cin;
        w_work_nxt  = r_work;
        w_carry_nxt = r_carry;
        w_sum_nxt   = r_sum;
        w_cout_nxt  = r_cout;
        case (r_state)
            c_IDLE, c_DONE: begin
                // DONE accepts start exactly like IDLE for back-to-back use
                if (start) begin
                    w_a_nxt     = a_in;
                    w_b_nxt     = b_in;
                    w_cin_nxt   = cin_in;
                    w_idx_nxt   = '0;
                    w_state_nxt = c_ADD;
                end else begin
                    w_state_nxt = c_IDLE;
                end
            end
            c_ADD: begin
                w_work_nxt  = w_work_upd;
                w_carry_nxt = add_cout;
                if (r_idx == c_LAST_IDX) begin
                    w_sum_nxt   = w_work_upd;
                    w_cout_nxt  = add_cout;
                    w_state_nxt = c_DONE;
                end else begin
                    w_idx_nxt   = r_idx + IDXW'(1);
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_cin   <= 1'b0;
            r_work  <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_cin   <= w_cin_nxt;
            r_work  <= w_work_nxt;
            r_carry <= w_carry_nxt;
            r_sum   <= w_sum_nxt;
            r_cout  <= w_cout_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_adder_operand_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_adder_operand_sequencer
// Description : Self-checking bench: vector table, scoreboard and corner cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_operand_sequencer;

    localparam int NWORDS = 4;
    localparam int W      = 8 * NWORDS;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [W-1:0]   a_in, b_in;
    logic           cin_in;
    logic           busy, done, cout_out;
    logic [W-1:0]   sum_out;
    logic [7:0]     add_a, add_b, add_s;
    logic           add_cin, add_cout;

    always #5 clk = ~clk;

    // Behavioural stand-in for the external combinational 8-bit adder
    assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};

    adder_operand_sequencer #(.NWORDS(NWORDS)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a_in     (a_in),
        .b_in     (b_in),
        .cin_in   (cin_in),
        .busy     (busy),
        .done     (done),
        .sum_out  (sum_out),
        .cout_out (cout_out),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_s    (add_s),
        .add_cout (add_cout)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
    } vec_t;

    vec_t         vecs [6];
    logic [W:0]   sb_q [$];
    int           n_tests = 0;
    int           n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding request
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1, expected no pending op");
            end else begin
                chk("sb_result", 64'({cout_out, sum_out}), 64'(sb_q.pop_front()));
            end
        end
    end

    task automatic wait_done(input string name, output int n);
        n = 0;
        while (!done && n < NWORDS + 4) begin
            tick();
            n++;
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: got no done after %0d cycles, expected done", name, n);
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic [W:0] exp, output int lat,
                          output logic [NWORDS-1:0] cins, output logic [7:0] a0,
                          output logic [7:0] b0);
        a_in = a; b_in = b; cin_in = cin; start = 1'b1;
        sb_q.push_back(exp);
        tick();
        start = 1'b0;
        a_in = $urandom; b_in = $urandom; cin_in = 1'($urandom);
        lat = 0; cins = '0; a0 = '0; b0 = '0;
        while (!done && lat < NWORDS + 4) begin
            if (busy && lat < NWORDS) cins[lat] = add_cin;
            if (lat == 0) begin a0 = add_a; b0 = add_b; end
            tick();
            lat++;
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL op_timeout: got no done after %0d cycles, expected done", lat);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int                lat;
        logic [NWORDS-1:0] cins;
        logic [7:0]        a0, b0;
        logic [W-1:0]      ra, rb;
        logic              rc;
        int                dcount;

        vecs[0] = '{32'h000000B5, 32'h000000A7, 1'b0, 32'h0000015C, 1'b0};
        vecs[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1};
        vecs[2] = '{32'h7FFFFFFF, 32'h00000000, 1'b1, 32'h80000000, 1'b0};
        vecs[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1};
        vecs[4] = '{32'h12345678, 32'h9ABCDEF0, 1'b0, 32'hACF13568, 1'b0};
        vecs[5] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1};

        // Reset with random inputs
        rst = 1'b1; start = 1'($urandom); a_in = $urandom; b_in = $urandom; cin_in = 1'($urandom);
        tick();
        start = 1'($urandom); a_in = $urandom; b_in = $urandom;
        tick();
        chk("rst_busy",    64'(busy),     64'd0);
        chk("rst_done",    64'(done),     64'd0);
        chk("rst_sum",     64'(sum_out),  64'd0);
        chk("rst_cout",    64'(cout_out), 64'd0);
        chk("rst_add_a",   64'(add_a),    64'd0);
        chk("rst_add_b",   64'(add_b),    64'd0);
        chk("rst_add_cin", 64'(add_cin),  64'd0);
        rst = 1'b0; start = 1'b0;
        tick();

        // Basic add: beat values and latency
        run_op(vecs[0].a, vecs[0].b, vecs[0].cin, {vecs[0].cout, vecs[0].sum}, lat, cins, a0, b0);
        chk("basic_latency", 64'(lat),     64'(NWORDS));
        chk("basic_beat0_a", 64'(a0),      64'hB5);
        chk("basic_beat0_b", 64'(b0),      64'hA7);
        chk("basic_cin0",    64'(cins[0]), 64'd0);
        chk("basic_cin1",    64'(cins[1]), 64'd1);
        chk("basic_busy_in_done", 64'(busy), 64'd0);
        tick();
        chk("done_one_cycle", 64'(done), 64'd0);
        chk("idle_busy",      64'(busy), 64'd0);
        chk("idle_add_a",     64'(add_a), 64'd0);

        // Full carry propagation through every byte
        run_op(vecs[1].a, vecs[1].b, vecs[1].cin, {vecs[1].cout, vecs[1].sum}, lat, cins, a0, b0);
        chk("fullcarry_cins", 64'(cins), 64'b1110);

        // Table of vectors, issued back-to-back from the DONE cycle
        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, {vecs[i].cout, vecs[i].sum}, lat, cins, a0, b0);
            chk($sformatf("vec%0d_sum", i),  64'(sum_out),  64'(vecs[i].sum));
            chk($sformatf("vec%0d_cout", i), 64'(cout_out), 64'(vecs[i].cout));
            chk($sformatf("vec%0d_lat", i),  64'(lat),      64'(NWORDS));
        end

        // Random operands, expectation from a full-width add
        for (int i = 0; i < 8; i++) begin
            ra = $urandom; rb = $urandom; rc = 1'($urandom);
            run_op(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + (W+1)'(rc), lat, cins, a0, b0);
        end
        start = 1'b0;
        tick();

        // start while busy is ignored; then back-to-back from DONE
        a_in = 32'h11111111; b_in = 32'h22222222; cin_in = 1'b0; start = 1'b1;
        sb_q.push_back(33'h033333333);
        tick();
        start = 1'b0;
        tick();
        tick();
        start = 1'b1; a_in = 32'hDEADBEEF; b_in = 32'hCAFEF00D; cin_in = 1'b1;
        tick();
        start = 1'b0;
        chk("ignored_start_still_busy", 64'(busy), 64'd1);
        wait_done("ignore", dcount);
        chk("ignored_start_sum", 64'(sum_out), 64'h33333333);
        a_in = 32'd1; b_in = 32'd2; cin_in = 1'b0; start = 1'b1;
        sb_q.push_back(33'd3);
        tick();
        start = 1'b0;
        chk("b2b_add_entered", 64'(busy),    64'd1);
        chk("b2b_sum_stable",  64'(sum_out), 64'h33333333);
        wait_done("b2b", dcount);
        chk("b2b_latency",     64'(dcount),  64'(NWORDS));
        chk("b2b_sum",         64'(sum_out), 64'd3);
        tick();

        // Reset mid-operation abandons the add
        a_in = 32'hFFFFFFFF; b_in = 32'h1; cin_in = 1'b0; start = 1'b1;
        sb_q.push_back(33'h100000000);
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb_q.delete();
        chk("midrst_busy", 64'(busy),     64'd0);
        chk("midrst_done", 64'(done),     64'd0);
        chk("midrst_sum",  64'(sum_out),  64'd0);
        chk("midrst_cout", 64'(cout_out), 64'd0);
        chk("midrst_cin",  64'(add_cin),  64'd0);
        dcount = 0;
        for (int i = 0; i < NWORDS + 2; i++) begin
            if (done) dcount++;
            tick();
        end
        chk("midrst_no_done", 64'(dcount), 64'd0);
        run_op(32'h0F0F0F0F, 32'hF0F0F0F0, 1'b1, 33'h100000000, lat, cins, a0, b0);
        chk("postrst_sum",  64'(sum_out),  64'd0);
        chk("postrst_cout", 64'(cout_out), 64'd1);
        tick();
        tick();
        chk("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adder_operand_sequencer.md
Name: adder_operand_sequencer

Overview:
- Upstream/downstream controller for the team's 8-bit ripple-carry adder stage (A, B, Cin in; S, Cout out).
- Accepts one wide operand pair of NWORDS bytes and drives the adder one byte per cycle, least-significant byte first.
- Chains the adder's carry-out into the next byte's carry-in, captures each byte of S, and presents the full-width sum and final carry with a done pulse.
- Lets the existing combinational 8-bit adder perform 8·NWORDS-bit additions.

Parameters:
- NWORDS, 4, number of 8-bit bytes per operand. Legal range 1..16; operand width W = 8*NWORDS.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request a new addition; sampled on rising edge
- a_in  input  W  operand A; captured when start is accepted
- b_in  input  W  operand B; captured when start is accepted
- cin_in  input  1  carry-in to byte 0; captured when start is accepted
- busy  output  1  high while bytes are being added (ADD state)
- done  output  1  one-cycle pulse: sum_out/cout_out just updated
- sum_out  output  W  registered result; held until the next completion
- cout_out  output  1  registered carry out of the top byte
- add_a  output  8  to adder A
- add_b  output  8  to adder B
- add_cin  output  1  to adder Cin
- add_s  input  8  from adder S (combinational return, same cycle)
- add_cout  input  1  from adder Cout (same cycle)

Behaviour:
- Reset (rst=1 at an edge), including mid-operation:
  - state goes to IDLE and byte index to 0.
  - busy=0, done=0, sum_out=0, cout_out=0.
  - Operand, working-sum and carry registers all cleared.
  - The operation in flight is abandoned; no done pulse follows.
- States: IDLE, ADD, DONE.
- IDLE: busy=0, done=0. add_a, add_b and add_cin are driven 0.
  - start=1 at an edge: latch a_in, b_in, cin_in; set idx=0; go to ADD.
- ADD: busy=1.
  - add_a = A_reg[8*idx+7:8*idx]; add_b = B_reg byte idx.
  - add_cin = cin_reg when idx==0, else carry_reg.
  - These outputs are decoded from registers only. The path to the adder and back must close within one cycle.
  - At each edge: write add_s into work byte idx; carry_reg <= add_cout.
  - If idx==NWORDS-1:
    - sum_out <= work with add_s placed in the top byte; cout_out <= add_cout.
    - done <= 1; go to DONE.
  - Else: idx <= idx+1.
- start while in ADD is ignored. Operands are not re-sampled.
- DONE: lasts exactly one cycle, with done=1 and busy=0.
  - start=1 at the edge leaving DONE is accepted as in IDLE (back-to-back, goes to ADD). Otherwise go to IDLE.
- Latency:
  - Start sampled at edge e0; done is high for the cycle after edge eNWORDS, i.e. NWORDS cycles after acceptance.
  - Throughput: one addition per NWORDS+1 cycles.
  - NWORDS=1: one ADD cycle, then DONE.
- sum_out and cout_out change only at the completing edge (or at reset). They are stable at all other times, including during a later operation.
- Arithmetic: sum_out = (A + B + cin) mod 2^W. cout_out = bit W of the full sum.
- Operand inputs may change freely after acceptance without affecting the result.

Test Plan:
- Reset: hold rst=1 for 2 cycles with random inputs -> busy=0, done=0, sum_out=0, cout_out=0, add_a=add_b=0, add_cin=0.
- Basic add, NWORDS=4: A=0x000000B5, B=0x000000A7, cin=0.
  - Beat 0: add_a=B5, add_b=A7, add_cin=0. Beat 1: add_cin=1.
  - done 4 cycles after start; sum_out=0x0000015C, cout_out=0.
- Full carry propagation: A=0xFFFFFFFF, B=0x00000001, cin=0.
  - add_cin=1 on beats 1..3.
  - sum_out=0x00000000, cout_out=1.
- Carry-in only: A=0x7FFFFFFF, B=0, cin=1 -> sum_out=0x80000000, cout_out=0.
- Start ignored while busy, then back-to-back:
  - Assert start with new operands during beat 2 -> first result unchanged.
  - Assert start in the DONE cycle with A=1, B=2 -> ADD entered immediately; next sum_out=3 after NWORDS more cycles.
- Reset mid-operation: rst=1 during beat 1 of 0xFFFFFFFF+1 -> outputs cleared, no done pulse. A fresh start then completes correctly.
